// File: rtl/cndm_ctrl_pkg.sv
// Register map and helpers shared by the Corundum-micro device control block.
package cndm_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [15:0] REG_FPGA_ID      = 16'h0000;
  localparam logic [15:0] REG_FW_ID        = 16'h0004;
  localparam logic [15:0] REG_FW_VER       = 16'h0008;
  localparam logic [15:0] REG_BOARD_ID     = 16'h000C;
  localparam logic [15:0] REG_BOARD_VER    = 16'h0010;
  localparam logic [15:0] REG_BUILD_DATE   = 16'h0014;
  localparam logic [15:0] REG_GIT_HASH     = 16'h0018;
  localparam logic [15:0] REG_RELEASE_INFO = 16'h001C;
  localparam logic [15:0] REG_SCRATCH      = 16'h0020;
  localparam logic [15:0] REG_PORTS        = 16'h0100;
  localparam logic [15:0] REG_PORT_OFFSET  = 16'h0104;
  localparam logic [15:0] REG_PORT_STRIDE  = 16'h0108;
  localparam logic [15:0] REG_IRQ_PEND     = 16'h0200;
  localparam logic [15:0] REG_IRQ_MASK     = 16'h0204;
  localparam logic [15:0] REG_IRQ_HOLDOFF  = 16'h0208;

  // Expands a byte strobe into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] strb_mask(input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W/8; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite bundle with separate write and read slave views.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int STRB_W = DATA_W/8,
  parameter int USER_W = 1
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, buser, bvalid
  );

  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, ruser, rvalid
  );
endinterface

// File: rtl/cndm_irq_moderator.sv
// Per-port interrupt moderation: pending latch, enable and holdoff timer.
module cndm_irq_moderator #(
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evt,
  input  logic                 clear,
  input  logic                 mask,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 pend,
  output logic                 irq
);

  logic [HOLDOFF_W-1:0] tmr;
  logic                 fire;

  assign fire = pend && mask && (tmr == '0);
  assign irq  = fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      tmr  <= '0;
    end else begin
      // A new event outranks both the fire and a W1C so it is never lost.
      if (evt)                pend <= 1'b1;
      else if (fire || clear) pend <= 1'b0;

      // The firing cycle counts as the first holdoff cycle, so pulses land HOLDOFF cycles apart.
      if (fire)             tmr <= (holdoff == '0) ? '0 : holdoff - HOLDOFF_W'(1);
      else if (tmr != '0)   tmr <= tmr - HOLDOFF_W'(1);
    end
  end

endmodule

// File: rtl/cndm_ctrl_regs.sv
// Device control window: ID registers, scratch, port layout and per-port IRQ moderation.
module cndm_ctrl_regs
  import cndm_ctrl_pkg::*;
#(
  parameter logic [31:0] FPGA_ID      = 32'hDEADBEEF,
  parameter logic [31:0] FW_ID        = 32'h0000C001,
  parameter logic [31:0] FW_VER       = 32'h000_01_000,
  parameter logic [31:0] BOARD_ID     = 32'h1234_0000,
  parameter logic [31:0] BOARD_VER    = 32'h001_00_000,
  parameter logic [31:0] BUILD_DATE   = 32'd602976000,
  parameter logic [31:0] GIT_HASH     = 32'h5f87c2e8,
  parameter logic [31:0] RELEASE_INFO = 32'h0,
  parameter int          PORTS        = 2,
  parameter logic [31:0] PORT_OFFSET  = 32'h00020000,
  parameter logic [31:0] PORT_STRIDE  = 32'h00010000,
  parameter int          HOLDOFF_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axil_if.wr_slv      s_axil_wr,
  taxi_axil_if.rd_slv      s_axil_rd,
  input  logic [PORTS-1:0] irq_in,
  output logic [PORTS-1:0] irq
);

  if (PORTS < 1 || PORTS > 32) begin : g_bad_ports
    $error("cndm_ctrl_regs: PORTS must be in 1..32");
  end
  if (HOLDOFF_W < 1 || HOLDOFF_W > 32) begin : g_bad_holdoff_w
    $error("cndm_ctrl_regs: HOLDOFF_W must be in 1..32");
  end

  logic                 awready_q, bvalid_q, arready_q, rvalid_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    scratch;
  logic [PORTS-1:0]     irq_mask;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [PORTS-1:0]     pend;
  logic [PORTS-1:0]     clear;

  logic [15:0]       wr_addr, rd_addr;
  logic              wr_go, rd_go;
  logic [DATA_W-1:0] bmask, wr_bits, mask_merge, holdoff_merge, rd_val;

  assign wr_addr = {s_axil_wr.awaddr[15:2], 2'b00};
  assign rd_addr = {s_axil_rd.araddr[15:2], 2'b00};
  assign wr_go   = s_axil_wr.awvalid && s_axil_wr.wvalid && !bvalid_q;
  assign rd_go   = s_axil_rd.arvalid && !rvalid_q;

  assign bmask         = strb_mask(s_axil_wr.wstrb);
  assign wr_bits       = s_axil_wr.wdata & bmask;
  assign mask_merge    = (DATA_W'(irq_mask) & ~bmask) | wr_bits;
  assign holdoff_merge = (DATA_W'(holdoff) & ~bmask) | wr_bits;
  assign clear         = (wr_go && wr_addr == REG_IRQ_PEND) ? wr_bits[PORTS-1:0] : '0;

  assign s_axil_wr.awready = awready_q;
  assign s_axil_wr.wready  = awready_q;
  assign s_axil_wr.bvalid  = bvalid_q;
  assign s_axil_wr.bresp   = 2'b00;
  assign s_axil_wr.buser   = '0;
  assign s_axil_rd.arready = arready_q;
  assign s_axil_rd.rvalid  = rvalid_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.rresp   = 2'b00;
  assign s_axil_rd.ruser   = '0;

  always_comb begin
    rd_val = '0;
    case (rd_addr)
      REG_FPGA_ID:      rd_val = FPGA_ID;
      REG_FW_ID:        rd_val = FW_ID;
      REG_FW_VER:       rd_val = FW_VER;
      REG_BOARD_ID:     rd_val = BOARD_ID;
      REG_BOARD_VER:    rd_val = BOARD_VER;
      REG_BUILD_DATE:   rd_val = BUILD_DATE;
      REG_GIT_HASH:     rd_val = GIT_HASH;
      REG_RELEASE_INFO: rd_val = RELEASE_INFO;
      REG_SCRATCH:      rd_val = scratch;
      REG_PORTS:        rd_val = DATA_W'(PORTS);
      REG_PORT_OFFSET:  rd_val = PORT_OFFSET;
      REG_PORT_STRIDE:  rd_val = PORT_STRIDE;
      REG_IRQ_PEND:     rd_val = DATA_W'(pend);
      REG_IRQ_MASK:     rd_val = DATA_W'(irq_mask);
      REG_IRQ_HOLDOFF:  rd_val = DATA_W'(holdoff);
      default:          rd_val = '0;
    endcase
  end

  // NOTE: registered state uses <= so every block samples the pre-edge value of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      scratch   <= '0;
      irq_mask  <= '0;
      holdoff   <= '0;
    end else begin
      awready_q <= wr_go;
      if (wr_go) begin
        bvalid_q <= 1'b1;
        case (wr_addr)
          REG_SCRATCH:     scratch  <= (scratch & ~bmask) | wr_bits;
          REG_IRQ_MASK:    irq_mask <= mask_merge[PORTS-1:0];
          REG_IRQ_HOLDOFF: holdoff  <= holdoff_merge[HOLDOFF_W-1:0];
          default: ;
        endcase
      end else if (s_axil_wr.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= rd_go;
      if (rd_go) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axil_rd.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    cndm_irq_moderator #(.HOLDOFF_W(HOLDOFF_W)) u_mod (
      .clk     (clk),
      .rst     (rst),
      .evt     (irq_in[p]),
      .clear   (clear[p]),
      .mask    (irq_mask[p]),
      .holdoff (holdoff),
      .pend    (pend[p]),
      .irq     (irq[p])
    );
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axil_wr.awaddr[1:0], s_axil_wr.awprot,
                       s_axil_rd.araddr[1:0], s_axil_rd.arprot};

endmodule
